// File: rtl/cpu_datapath.sv
// Execution datapath: 8x16 register file, A/B operand registers, shifter, ALU, C result and Z/N/V status.
// Optional macro CPU_DATAPATH_RF_BYPASS_EN makes a same-index register read return the pending write value.
module cpu_datapath #(
    parameter int WIDTH = 16,
    parameter int NREGS = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [$clog2(NREGS)-1:0] readnum,
    input  logic [$clog2(NREGS)-1:0] writenum,
    input  logic                     write,
    input  logic                     vsel,
    input  logic [WIDTH-1:0]         sximm8,
    input  logic [WIDTH-1:0]         sximm5,
    input  logic                     loada,
    input  logic                     loadb,
    input  logic                     asel,
    input  logic                     bsel,
    input  logic [1:0]               shift,
    input  logic [1:0]               ALUop,
    input  logic                     loadc,
    input  logic                     loads,
    output logic [WIDTH-1:0]         datapath_out,
    output logic                     Z,
    output logic                     N,
    output logic                     V
);

    localparam int SELW = $clog2(NREGS);

    logic [WIDTH-1:0] rf_q [NREGS];
    logic [WIDTH-1:0] rf_d [NREGS];
    logic [WIDTH-1:0] wr_data;
    logic [WIDTH-1:0] rf_rdata;

    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] c_q, c_d;
    logic [2:0]       status_q, status_d;

    logic [WIDTH-1:0] sout;
    logic [WIDTH-1:0] ain;
    logic [WIDTH-1:0] bin;
    logic [WIDTH-1:0] alu_result;
    logic             z_flag;
    logic             n_flag;
    logic             v_flag;

    assign wr_data = vsel ? sximm8 : c_q;

    always_comb begin
        for (int i = 0; i < NREGS; i++) begin
            rf_d[i] = rf_q[i];
            if (write && (writenum == SELW'(i))) begin
                rf_d[i] = wr_data;
            end
        end
    end

    // Without the bypass, a read of the index being written sees the old contents.
    always_comb begin
        rf_rdata = rf_q[readnum];
`ifdef CPU_DATAPATH_RF_BYPASS_EN
        if (write && (readnum == writenum)) begin
            rf_rdata = wr_data;
        end
`endif
    end

    always_comb begin
        a_d = loada ? rf_rdata : a_q;
        b_d = loadb ? rf_rdata : b_q;
    end

    always_comb begin
        case (shift)
            2'b00:   sout = b_q;
            2'b01:   sout = {b_q[WIDTH-2:0], 1'b0};
            2'b10:   sout = {1'b0, b_q[WIDTH-1:1]};
            default: sout = {b_q[WIDTH-1], b_q[WIDTH-1:1]};
        endcase
    end

    assign ain = asel ? '0 : a_q;
    assign bin = bsel ? sximm5 : sout;

    // Carry-out is dropped; overflow is judged on operand and result sign bits.
    always_comb begin
        v_flag = 1'b0;
        case (ALUop)
            2'b00: begin
                alu_result = ain + bin;
                v_flag     = (ain[WIDTH-1] == bin[WIDTH-1]) && (alu_result[WIDTH-1] != ain[WIDTH-1]);
            end
            2'b01: begin
                alu_result = ain - bin;
                v_flag     = (ain[WIDTH-1] != bin[WIDTH-1]) && (alu_result[WIDTH-1] != ain[WIDTH-1]);
            end
            2'b10:   alu_result = ain & bin;
            default: alu_result = ~bin;
        endcase
        z_flag = (alu_result == '0);
        n_flag = alu_result[WIDTH-1];
    end

    always_comb begin
        c_d      = loadc ? alu_result : c_q;
        status_d = loads ? {z_flag, n_flag, v_flag} : status_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                rf_q[i] <= '0;
            end
            a_q      <= '0;
            b_q      <= '0;
            c_q      <= '0;
            status_q <= '0;
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                rf_q[i] <= rf_d[i];
            end
            a_q      <= a_d;
            b_q      <= b_d;
            c_q      <= c_d;
            status_q <= status_d;
        end
    end

    assign datapath_out = c_q;
    assign Z            = status_q[2];
    assign N            = status_q[1];
    assign V            = status_q[0];

endmodule

// File: tb/tb_cpu_datapath.sv
// Scoreboard bench for cpu_datapath: expectations queued with each stimulus cycle, compared after the edge.
// Honours CPU_DATAPATH_RF_BYPASS_EN for the same-cycle read/write expectation.
module tb_cpu_datapath;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  readnum, writenum;
    logic        write, vsel;
    logic [15:0] sximm8, sximm5;
    logic        loada, loadb, asel, bsel;
    logic [1:0]  shift, ALUop;
    logic        loadc, loads;
    logic [15:0] datapath_out;
    logic        Z, N, V;

    int checks   = 0;
    int failures = 0;

    // Queue entries: bit 16 selects what is compared (0 = C, 1 = {Z,N,V}).
    string       tag_q[$];
    logic [16:0] exp_q[$];

    cpu_datapath dut (
        .clk(clk), .reset(reset), .readnum(readnum), .writenum(writenum),
        .write(write), .vsel(vsel), .sximm8(sximm8), .sximm5(sximm5),
        .loada(loada), .loadb(loadb), .asel(asel), .bsel(bsel),
        .shift(shift), .ALUop(ALUop), .loadc(loadc), .loads(loads),
        .datapath_out(datapath_out), .Z(Z), .N(N), .V(V)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%04h expected=0x%04h", tag, got, exp);
        end else begin
            $display("ok   %s = 0x%04h", tag, got);
        end
    endtask

    task automatic expect_c(input string tag, input logic [15:0] exp);
        tag_q.push_back(tag);
        exp_q.push_back({1'b0, exp});
    endtask

    task automatic expect_flags(input string tag, input logic [2:0] znv);
        tag_q.push_back(tag);
        exp_q.push_back({1'b1, 13'd0, znv});
    endtask

    task automatic drain();
        string       t;
        logic [16:0] e;
        while (exp_q.size() > 0) begin
            t = tag_q.pop_front();
            e = exp_q.pop_front();
            if (e[16]) check_eq(t, {13'd0, Z, N, V}, e[15:0]);
            else       check_eq(t, datapath_out, e[15:0]);
        end
    endtask

    task automatic clear_strobes();
        reset = 1'b0; write = 1'b0; loada = 1'b0; loadb = 1'b0;
        loadc = 1'b0; loads = 1'b0; vsel  = 1'b0; asel  = 1'b0;
        bsel  = 1'b0; shift = 2'b00; ALUop = 2'b00;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        drain();
        clear_strobes();
    endtask

    task automatic write_imm(input logic [2:0] r, input logic [15:0] v);
        writenum = r; sximm8 = v; vsel = 1'b1; write = 1'b1;
        step();
    endtask

    task automatic load_ab(input logic [2:0] ra, input logic [2:0] rb);
        readnum = ra; loada = 1'b1; step();
        readnum = rb; loadb = 1'b1; step();
    endtask

    // Reads R[r] out through B and the ALU (0 + B) into C; flags untouched.
    task automatic read_reg(input logic [2:0] r, input logic [15:0] exp, input string tag);
        readnum = r; loadb = 1'b1; step();
        asel = 1'b1; bsel = 1'b0; shift = 2'b00; ALUop = 2'b00; loadc = 1'b1;
        expect_c(tag, exp);
        step();
    endtask

    // Exposes A in C as A + sximm5(=0).
    task automatic read_a(input logic [15:0] exp, input string tag);
        asel = 1'b0; bsel = 1'b1; sximm5 = 16'h0000; ALUop = 2'b00; loadc = 1'b1;
        expect_c(tag, exp);
        step();
    endtask

    logic [15:0] rw_exp;

    initial begin
        readnum = '0; writenum = '0; sximm8 = '0; sximm5 = '0;
        clear_strobes();
        reset = 1'b1;
        step();
        reset = 1'b1;
        step();

        // Make state non-zero, then reset with loadc asserted in the same cycle.
        write_imm(3'd3, 16'h1234);
        load_ab(3'd3, 3'd3);
        asel = 1'b1; bsel = 1'b1; sximm5 = 16'h0005; ALUop = 2'b00; loadc = 1'b1; loads = 1'b1;
        step();
        reset = 1'b1; loadc = 1'b1; loads = 1'b1; asel = 1'b1; bsel = 1'b1;
        sximm5 = 16'h8001; ALUop = 2'b00;
        expect_c("reset_c", 16'h0000);
        expect_flags("reset_flags", 3'b000);
        step();
        read_a(16'h0000, "reset_a");
        asel = 1'b1; bsel = 1'b0; shift = 2'b00; ALUop = 2'b00; loadc = 1'b1;
        expect_c("reset_b", 16'h0000);
        step();
        for (int i = 0; i < 8; i++) begin
            read_reg(3'(i), 16'h0000, $sformatf("reset_r%0d", i));
        end

        // Immediate writes and ADD with B<<1: 7 + (2<<1) = 11.
        write_imm(3'd0, 16'h0007);
        write_imm(3'd1, 16'h0002);
        load_ab(3'd0, 3'd1);
        shift = 2'b01; ALUop = 2'b00; loadc = 1'b1; loads = 1'b1;
        expect_c("add_c", 16'h000B);
        expect_flags("add_flags", 3'b000);
        step();
        writenum = 3'd2; vsel = 1'b0; write = 1'b1;
        step();
        read_reg(3'd2, 16'h000B, "add_r2");

        // CMP: 0x8000 - 1 overflows; C keeps 0x000B from the read-back.
        write_imm(3'd5, 16'h8000);
        write_imm(3'd6, 16'h0001);
        load_ab(3'd5, 3'd6);
        shift = 2'b00; ALUop = 2'b01; loads = 1'b1;
        expect_c("cmp_c_held", 16'h000B);
        expect_flags("cmp_flags", 3'b001);
        step();

        // AND to zero.
        write_imm(3'd5, 16'h00F0);
        write_imm(3'd6, 16'h0F0F);
        load_ab(3'd5, 3'd6);
        ALUop = 2'b10; loadc = 1'b1; loads = 1'b1;
        expect_c("and_c", 16'h0000);
        expect_flags("and_flags", 3'b100);
        step();

        // MVN of arithmetic and logical right shifts of 0x8004.
        write_imm(3'd6, 16'h8004);
        readnum = 3'd6; loadb = 1'b1; step();
        asel = 1'b1; shift = 2'b11; ALUop = 2'b11; loadc = 1'b1; loads = 1'b1;
        expect_c("mvn_asr_c", 16'h3FFD);
        expect_flags("mvn_asr_flags", 3'b000);
        step();
        asel = 1'b1; shift = 2'b10; ALUop = 2'b11; loadc = 1'b1; loads = 1'b1;
        expect_c("mvn_lsr_c", 16'hBFFD);
        expect_flags("mvn_lsr_flags", 3'b010);
        step();

        // A and B captured together from R7: 0x4000 + 0x4000 overflows positive.
        write_imm(3'd7, 16'h4000);
        readnum = 3'd7; loada = 1'b1; loadb = 1'b1; step();
        ALUop = 2'b00; loadc = 1'b1; loads = 1'b1;
        expect_c("addv_c", 16'h8000);
        expect_flags("addv_flags", 3'b011);
        step();

        // Same-cycle read and write of R4.
        write_imm(3'd4, 16'h0001);
        writenum = 3'd4; sximm8 = 16'h00AA; vsel = 1'b1; write = 1'b1;
        readnum = 3'd4; loada = 1'b1;
        step();
`ifdef CPU_DATAPATH_RF_BYPASS_EN
        rw_exp = 16'h00AA;
`else
        rw_exp = 16'h0001;
`endif
        read_a(rw_exp, "rw_a");
        read_reg(3'd4, 16'h00AA, "rw_r4");

        // Reset wins over loadc/loads once more, from a non-zero C and flags.
        reset = 1'b1; loadc = 1'b1; loads = 1'b1; asel = 1'b1; bsel = 1'b1;
        sximm5 = 16'hFFFF; ALUop = 2'b00;
        expect_c("reset2_c", 16'h0000);
        expect_flags("reset2_flags", 3'b000);
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
